mem_arbiter: RTL

//  Shares the single-ported multi-cycle memory between the core's instruction-fetch port (i_*)
//  and its load/store port (d_*). One transaction reaches memory at a time; the grant is held

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported multi-cycle memory between the fetch (i_*) and load/store (d_*) ports,
// with a response watchdog. Define ARB_RR_EN for round-robin arbitration; the default is data-first.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, REL} state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                last_grant_q, last_grant_d;
  logic                req_read_q, req_read_d;
  logic                req_write_q, req_write_d;
  logic [3:0]          req_wmask_q, req_wmask_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

  logic busy;
  logic timeout;
  logic pick_d;

  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign timeout = (TIMEOUT != 0) && busy && !mem_resp && (wdog_q == WDOG_LAST);

`ifdef ARB_RR_EN
  // With both ports pending, the port that did not win last time is served.
  assign pick_d = (d_read || d_write) && (!i_read || (last_grant_q == GRANT_I));
`else
  assign pick_d = d_read || d_write;
`endif

  // NOTE: reset is synchronous, and every flop uses <= so all state updates land together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      last_grant_q <= GRANT_I;
      req_read_q   <= 1'b0;
      req_write_q  <= 1'b0;
      req_wmask_q  <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      last_grant_q <= last_grant_d;
      req_read_q   <= req_read_d;
      req_write_q  <= req_write_d;
      req_wmask_q  <= req_wmask_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    wdog_d       = '0;
    last_grant_d = last_grant_q;
    req_read_d   = req_read_q;
    req_write_d  = req_write_q;
    req_wmask_d  = req_wmask_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    case (state_q)
      IDLE: begin
        // The granted request is captured so a requester dropping it early cannot abort memory.
        if (pick_d) begin
          state_d     = BUSY_D;
          req_read_d  = d_read;
          req_write_d = d_write;
          req_wmask_d = d_wmask;
          req_addr_d  = d_address;
          req_wdata_d = d_wdata;
        end else if (i_read) begin
          state_d     = BUSY_I;
          req_read_d  = 1'b1;
          req_write_d = 1'b0;
          req_wmask_d = '0;
          req_addr_d  = i_address;
          req_wdata_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        wdog_d = wdog_q + 1'b1;
        if (mem_resp || timeout) begin
          state_d      = REL;
          last_grant_d = (state_q == BUSY_D) ? GRANT_D : GRANT_I;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_resp      = 1'b0;
    i_rdata     = '0;
    d_resp      = 1'b0;
    d_rdata     = '0;
    err         = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = '0;
    mem_address = '0;
    mem_wdata   = '0;
    if (busy) begin
      // Dropping the strobes in the response cycle keeps memory from starting a second access.
      mem_read    = req_read_q && !mem_resp;
      mem_write   = req_write_q && !mem_resp;
      mem_wmask   = req_wmask_q;
      mem_address = req_addr_q;
      mem_wdata   = req_wdata_q;
      if (mem_resp || timeout) begin
        err = timeout;
        if (state_q == BUSY_I) begin
          i_resp  = 1'b1;
          i_rdata = mem_resp ? mem_rdata : '0;
        end else begin
          d_resp  = 1'b1;
          d_rdata = mem_resp ? mem_rdata : '0;
        end
      end
    end
  end

endmodule
